// File: rtl/addsub_pkg.sv
// Shared types and helpers for the segmented add/sub pipeline.
// Saturating output is enabled by defining ADDSUB_SAT_EN.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Returns 0 for an illegal split so the top can refuse it.
  function automatic int stages_f(input int w, input int s);
    if (s <= 0 || w <= 0) return 0;
    if (w % s != 0) return 0;
    return w / s;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG-bit slice of the carry chain.
// Purely combinational; the top registers its outputs.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_c,
  output logic [SEG-1:0] o_s,
  output logic           o_c
);

  logic [SEG:0] w_full;

  assign w_full = {1'b0, i_a}
                + {1'b0, i_b}
                + {{SEG{1'b0}}, i_c};
  assign o_s = w_full[SEG-1:0];
  assign o_c = w_full[SEG];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/sub, one SEG-bit carry segment per stage.
// Define ADDSUB_SAT_EN to clamp the result on signed overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = stages_f(WIDTH, SEG);

  if (STAGES < 1 || STAGES > 16) begin : g_cfg_err
    $error("addsub_pipe: WIDTH must be SEG times 1..16");
  end

  logic             w_adv;
  logic             r_out_v;
  logic [WIDTH-1:0] r_sum;
  flags_t           r_flags;

  assign w_adv    = !r_out_v || out_ready;
  assign in_ready = w_adv;

  // Stage k adds segment k; unused upper operand bits ride along.
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int HW = WIDTH - LO;

    logic [HW-1:0]     w_a;
    logic [HW-1:0]     w_bx;
    logic              w_cin;
    logic              w_vin;
    logic              w_cout;
    logic [SEG-1:0]    w_seg;
    logic [LO+SEG-1:0] w_sum;

    if (k == 0) begin : g_in
      assign w_a   = in_a;
      assign w_bx  = (in_op == OP_SUB) ? ~in_b : in_b;
      assign w_cin = in_cin;
      assign w_vin = in_valid;
      assign w_sum = w_seg;
    end else begin : g_in
      assign w_a   = g_st[k-1].g_reg.r_a;
      assign w_bx  = g_st[k-1].g_reg.r_bx;
      assign w_cin = g_st[k-1].g_reg.r_c;
      assign w_vin = g_st[k-1].g_reg.r_v;
      assign w_sum = {w_seg, g_st[k-1].g_reg.r_s};
    end

    addsub_seg #(
      .SEG(SEG)
    ) u_seg (
      .i_a(w_a[SEG-1:0]),
      .i_b(w_bx[SEG-1:0]),
      .i_c(w_cin),
      .o_s(w_seg),
      .o_c(w_cout)
    );

    if (k < STAGES - 1) begin : g_reg
      logic              r_v;
      logic              r_c;
      logic [LO+SEG-1:0] r_s;
      logic [HW-SEG-1:0] r_a;
      logic [HW-SEG-1:0] r_bx;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v  <= 1'b0;
          r_c  <= 1'b0;
          r_s  <= '0;
          r_a  <= '0;
          r_bx <= '0;
        end else if (w_adv) begin
          r_v  <= w_vin;
          r_c  <= w_cout;
          r_s  <= w_sum;
          r_a  <= w_a[HW-1:SEG];
          r_bx <= w_bx[HW-1:SEG];
        end
      end
    end
  end

  logic             w_vlast;
  logic             w_clast;
  logic             w_msb_a;
  logic             w_msb_b;
  logic             w_ovf;
  logic [WIDTH-1:0] w_wrap;
  logic [WIDTH-1:0] w_res;

  assign w_vlast = g_st[STAGES-1].w_vin;
  assign w_clast = g_st[STAGES-1].w_cout;
  assign w_wrap  = g_st[STAGES-1].w_sum;
  assign w_msb_a = g_st[STAGES-1].w_a[SEG-1];
  assign w_msb_b = g_st[STAGES-1].w_bx[SEG-1];
  assign w_ovf   = (w_msb_a == w_msb_b)
                && (w_wrap[WIDTH-1] != w_msb_a);

`ifdef ADDSUB_SAT_EN
  // Both operands negative means the clamp goes to the most negative value.
  assign w_res = !w_ovf ? w_wrap
               : w_msb_a ? {1'b1, {(WIDTH-1){1'b0}}}
               : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_res = w_wrap;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_sum   <= '0;
      r_flags <= '0;
    end else if (w_adv) begin
      r_out_v      <= w_vlast;
      r_sum        <= w_res;
      r_flags.cout <= w_clast;
      r_flags.ovf  <= w_ovf;
      r_flags.zero <= (w_res == '0);
    end
  end

  assign out_valid = r_out_v;
  assign out_sum   = r_sum;
  assign out_cout  = r_flags.cout;
  assign out_ovf   = r_flags.ovf;
  assign out_zero  = r_flags.zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed and scoreboard bench for addsub_pipe.
// Covers the 16/4 pipeline and an 8/8 single-stage instance.
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v16, rdy16, op16, cin16, ov16, ordy16;
  logic        co16, ovf16, z16;
  logic [15:0] a16, b16, sum16;

  logic       v8, rdy8, op8, cin8, ov8, ordy8;
  logic       co8, ovf8, z8;
  logic [7:0] a8, b8, sum8;

  addsub_pipe #(.WIDTH(16), .SEG(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16),
    .in_op(op16), .in_cin(cin16),
    .out_valid(ov16), .out_ready(ordy16),
    .out_sum(sum16), .out_cout(co16),
    .out_ovf(ovf16), .out_zero(z16)
  );

  addsub_pipe #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8),
    .in_a(a8), .in_b(b8),
    .in_op(op8), .in_cin(cin8),
    .out_valid(ov8), .out_ready(ordy8),
    .out_sum(sum8), .out_cout(co8),
    .out_ovf(ovf8), .out_zero(z8)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Independent reference: signed arithmetic on integers.
  // Returns {zero, ovf, cout, sum[15:0]}.
  function automatic logic [18:0] model(input int w,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic op,
                                        input logic cin);
    longint m, half, au, bu, bx, full, s, sa, sb, ideal;
    logic c, o;
    logic [15:0] s16;
    m    = (longint'(1) << w) - 1;
    half = (m + 1) / 2;
    au   = longint'(a) & m;
    bu   = longint'(b) & m;
    bx   = op ? (~bu & m) : bu;
    full = au + bx + longint'(cin);
    c    = ((full >> w) & 1) != 0;
    s    = full & m;
    sa   = (au >= half) ? au - (m + 1) : au;
    sb   = (bu >= half) ? bu - (m + 1) : bu;
    ideal = op ? sa - sb - 1 + longint'(cin)
               : sa + sb + longint'(cin);
    o    = (ideal > half - 1) || (ideal < -half);
`ifdef ADDSUB_SAT_EN
    if (o) s = (ideal > 0) ? half - 1 : half;
`endif
    s16 = s[15:0];
    return {s16 == 16'h0, o, c, s16};
  endfunction

  task automatic run16(input string tag,
                       input logic [15:0] a, b,
                       input logic op, cin,
                       input logic [15:0] es,
                       input logic ec, eo, ez,
                       output logic [15:0] gs,
                       output logic gc);
    int cyc;
    @(negedge clk);
    a16 = a; b16 = b; op16 = op; cin16 = cin; v16 = 1'b1;
    #1 chk({tag, ".rdy"}, 32'(rdy16), 32'd1);
    @(negedge clk);
    v16 = 1'b0;
    cyc = 1;
    while (!ov16 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'd4);
    chk({tag, ".sum"}, 32'(sum16), 32'(es));
    chk({tag, ".cout"}, 32'(co16), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf16), 32'(eo));
    chk({tag, ".zero"}, 32'(z16), 32'(ez));
    gs = sum16;
    gc = co16;
  endtask

  logic [15:0] s_lo, s_hi, snap, dummy_s;
  logic        c_lo, c_hi, dummy_c, stall_prev, seen;
  logic [18:0] q[$];
  logic [18:0] e;
  int          sent, rcvd;

  initial begin
    rst_n = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; op16 = 1'b0; cin16 = 1'b0;
    ordy16 = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; op8 = 1'b0; cin8 = 1'b0;
    ordy8 = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(ov16), 32'd0);
    chk("rst.sum", 32'(sum16), 32'd0);
    chk("rst.flags", 32'({co16, ovf16, z16}), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst.ready", 32'(rdy16), 32'd1);

    run16("add1", 16'h1234, 16'h0001, OP_ADD, 1'b0,
          16'h1235, 1'b0, 1'b0, 1'b0, dummy_s, dummy_c);
    run16("sub1", 16'h0005, 16'h0007, OP_SUB, 1'b1,
          16'hFFFE, 1'b0, 1'b0, 1'b0, dummy_s, dummy_c);
`ifdef ADDSUB_SAT_EN
    run16("subov", 16'h8000, 16'h0001, OP_SUB, 1'b1,
          16'h8000, 1'b1, 1'b1, 1'b0, dummy_s, dummy_c);
    run16("addov", 16'h7FFF, 16'h0001, OP_ADD, 1'b0,
          16'h7FFF, 1'b0, 1'b1, 1'b0, dummy_s, dummy_c);
`else
    run16("subov", 16'h8000, 16'h0001, OP_SUB, 1'b1,
          16'h7FFF, 1'b1, 1'b1, 1'b0, dummy_s, dummy_c);
    run16("addov", 16'h7FFF, 16'h0001, OP_ADD, 1'b0,
          16'h8000, 1'b0, 1'b1, 1'b0, dummy_s, dummy_c);
`endif
    run16("ripple", 16'hFFFF, 16'h0001, OP_ADD, 1'b0,
          16'h0000, 1'b1, 1'b0, 1'b1, dummy_s, dummy_c);
    run16("cin", 16'h000F, 16'h0000, OP_ADD, 1'b1,
          16'h0010, 1'b0, 1'b0, 1'b0, dummy_s, dummy_c);
    run16("subz", 16'h0000, 16'h0000, OP_SUB, 1'b1,
          16'h0000, 1'b1, 1'b0, 1'b1, dummy_s, dummy_c);

    // 32-bit chain across two beats.
    run16("chl", 16'hFFFF, 16'h0001, OP_ADD, 1'b0,
          16'h0000, 1'b1, 1'b0, 1'b1, s_lo, c_lo);
    run16("chh", 16'h0001, 16'h0000, OP_ADD, c_lo,
          16'h0002, 1'b0, 1'b0, 1'b0, s_hi, c_hi);
    chk("ch32", {s_hi, s_lo}, 32'h0002_0000);

    // Streaming with a 3-cycle output stall.
    sent = 0; rcvd = 0; stall_prev = 1'b0; snap = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      ordy16 = !(cyc >= 5 && cyc <= 7);
      v16    = (sent < 8);
      a16    = 16'(sent * 16'h1111 + 16'h000F);
      b16    = 16'h00F3 ^ 16'(sent);
      op16   = sent[0];
      cin16  = sent[0];
      #1;
      if (ov16 && !ordy16)
        chk("bp.rdy", 32'(rdy16), 32'd0);
      if (stall_prev)
        chk("bp.hold", 32'(sum16), 32'(snap));
      stall_prev = ov16 && !ordy16;
      snap = sum16;
      if (ov16 && ordy16) begin
        if (q.size() == 0) begin
          chk("bp.extra", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("bp.sum", 32'(sum16), 32'(e[15:0]));
          chk("bp.cout", 32'(co16), 32'(e[16]));
        end
        rcvd++;
      end
      if (v16 && rdy16) begin
        q.push_back(model(16, a16, b16, op16, cin16));
        sent++;
      end
      @(negedge clk);
    end
    v16 = 1'b0;
    ordy16 = 1'b1;
    chk("bp.count", 32'(rcvd), 32'd8);
    chk("bp.sent", 32'(sent), 32'd8);

    // Reset with one beat on the output and three in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a16 = 16'h0100 + 16'(i); b16 = 16'h0011;
      op16 = OP_ADD; cin16 = 1'b0; v16 = 1'b1;
    end
    @(negedge clk);
    v16 = 1'b0;
    chk("mr.pre", 32'(ov16), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr.valid", 32'(ov16), 32'd0);
    chk("mr.sum", 32'(sum16), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr.ready", 32'(rdy16), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) seen = 1'b1;
    end
    chk("mr.noout", 32'(seen), 32'd0);
    run16("mr.new", 16'h4321, 16'h1111, OP_SUB, 1'b1,
          16'h3210, 1'b1, 1'b0, 1'b0, dummy_s, dummy_c);

    // Single-stage 8-bit instance against the model.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      op8 = 1'($urandom); cin8 = 1'($urandom);
      if (i == 0) begin a8 = 8'h7F; b8 = 8'h01; op8 = 1'b0; cin8 = 1'b0; end
      if (i == 1) begin a8 = 8'h80; b8 = 8'h01; op8 = 1'b1; cin8 = 1'b1; end
      v8 = 1'b1;
      e = model(8, {8'h00, a8}, {8'h00, b8}, op8, cin8);
      @(negedge clk);
      v8 = 1'b0;
      chk("s1.valid", 32'(ov8), 32'd1);
      chk("s1.sum", 32'(sum8), 32'(e[7:0]));
      chk("s1.flags", 32'({co8, ovf8, z8}),
          32'({e[16], e[17], e[18]}));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
